// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder: request side carries sel/imm,
// response side carries the packed field with its sel and representability flag.
interface imm_encoder_if;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned FIELD_W = 20;
  localparam int unsigned SEL_W   = 2;

  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic [IMM_W-1:0]   in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] out_field;
  logic [SEL_W-1:0]   out_sel;
  logic               out_err;

  modport slave (
    input  in_valid, in_sel, in_imm, out_ready,
    output in_ready, out_valid, out_field, out_sel, out_err
  );

  modport master (
    output in_valid, in_sel, in_imm, out_ready,
    input  in_ready, out_valid, out_field, out_sel, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Inverse immediate generator: range-checks a 32-bit immediate for the selected
// format and packs it into the generator's 20-bit raw field (2-stage pipeline).
module imm_encoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  imm_encoder_if.slave      bus,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned IMM_W   = 32;
  localparam int unsigned FIELD_W = 20;
  localparam int unsigned SEL_W   = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic               s1_v_q;
  logic [SEL_W-1:0]   s1_sel_q;
  logic [IMM_W-1:0]   s1_imm_q;
  logic               s2_v_q;
  logic [FIELD_W-1:0] s2_field_q;
  logic [SEL_W-1:0]   s2_sel_q;
  logic               s2_err_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   err_cnt_d;

  logic               s1_adv;
  logic               s2_adv;
  logic               deliver;
  logic [FIELD_W-1:0] field_c;
  logic               err_c;

  assign s2_adv  = ~s2_v_q | bus.out_ready;
  assign s1_adv  = ~s1_v_q | s2_adv;
  assign deliver = s2_v_q & bus.out_ready;

  // Field packing and representability check on the s1 contents.
  always_comb begin
    field_c = '0;
    err_c   = 1'b0;
    case (s1_sel_q)
      2'd0: begin
        field_c = {8'h00, s1_imm_q[11:0]};
        err_c   = ~((&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]));
      end
      2'd1: begin
        field_c = {8'h00, s1_imm_q[12:1]};
        err_c   = s1_imm_q[0] | ~((&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]));
      end
      2'd2: begin
        field_c = s1_imm_q[31:12];
        err_c   = |s1_imm_q[11:0];
      end
      2'd3: begin
        field_c = s1_imm_q[20:1];
        err_c   = s1_imm_q[0] | ~((&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]));
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_sel_q <= '0;
      s1_imm_q <= '0;
    end else if (s1_adv) begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sel_q <= bus.in_sel;
        s1_imm_q <= bus.in_imm;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q     <= 1'b0;
      s2_field_q <= '0;
      s2_sel_q   <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_field_q <= field_c;
        s2_sel_q   <= s1_sel_q;
        s2_err_q   <= err_c;
      end
    end
  end

  // Clear wins over a same-cycle errored delivery; count sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (deliver && s2_err_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v_q;
  assign bus.out_field = s2_field_q;
  assign bus.out_sel   = s2_sel_q;
  assign bus.out_err   = s2_err_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed vector table, stall/reset sequences and a
// random round-trip run, all checked through an in-order scoreboard.
module tb_imm_encoder;

  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = 3;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [19:0] field;
    logic        err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  int          n_deliv = 0;
  vec_t        q[$];
  vec_t        pend;
  vec_t        tbl[14];
  logic        smp_acc, smp_fire, smp_valid, smp_ready, smp_err;
  logic [19:0] smp_field;
  logic [1:0]  smp_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [31:0] imm,
                              input logic [19:0] field, input logic err);
    vec_t v;
    v.sel = sel; v.imm = imm; v.field = field; v.err = err;
    return v;
  endfunction

  // Reference encoder written from the value ranges of each format.
  function automatic vec_t model(input logic [1:0] sel, input logic [31:0] imm);
    vec_t v;
    int   s;
    logic ok;
    s = int'(imm);
    v.sel = sel; v.imm = imm;
    case (sel)
      2'd0: begin ok = (s >= -2048) && (s <= 2047); v.field = {8'h00, imm[11:0]}; end
      2'd1: begin ok = !imm[0] && (s >= -4096) && (s <= 4095); v.field = {8'h00, imm[12:1]}; end
      2'd2: begin ok = (imm[11:0] == 12'h000); v.field = imm[31:12]; end
      default: begin ok = !imm[0] && (s >= -1048576) && (s <= 1048575); v.field = imm[20:1]; end
    endcase
    v.err = !ok;
    return v;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [1:0] sel, input logic [19:0] f);
    case (sel)
      2'd0:    return {{20{f[11]}}, f[11:0]};
      2'd1:    return {{19{f[11]}}, f[11:0], 1'b0};
      2'd2:    return {f, 12'h000};
      default: return {{11{f[19]}}, f, 1'b0};
    endcase
  endfunction

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_sel   = v.sel;
    bus.in_imm   = v.imm;
    pend         = v;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One clock: sample just after the falling edge, score, then return at the next falling edge.
  task automatic cycle();
    vec_t e;
    logic e_err;
    #1;
    chk("err_cnt_track", 32'(err_cnt), 32'(exp_cnt));
    smp_acc   = bus.in_valid & bus.in_ready;
    smp_fire  = bus.out_valid & bus.out_ready;
    smp_valid = bus.out_valid;
    smp_ready = bus.in_ready;
    smp_field = bus.out_field;
    smp_sel   = bus.out_sel;
    smp_err   = bus.out_err;
    e_err     = 1'b0;
    if (smp_fire) begin
      n_deliv++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got field %0h sel %0d with nothing pending", smp_field, smp_sel);
      end else begin
        e = q.pop_front();
        chk("out_field", 32'(smp_field), 32'(e.field));
        chk("out_sel", 32'(smp_sel), 32'(e.sel));
        chk("out_err", 32'(smp_err), 32'(e.err));
        e_err = e.err;
        if (!smp_err) chk("round_trip", imm_gen(smp_sel, smp_field), e.imm);
      end
    end
    if (smp_acc) q.push_back(pend);
    if (clr_cnt) exp_cnt = 0;
    else if (smp_fire && e_err && exp_cnt < CMAX) exp_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Back-to-back burst with out_ready high; results must emerge on consecutive cycles.
  task automatic stream(input int lo, input int hi);
    for (int k = 0; k <= hi - lo + 2; k++) begin
      if (k <= hi - lo) drive(tbl[lo + k]);
      else idle();
      cycle();
      if (k >= 2) chk("stream_consec", 32'(smp_fire), 32'd1);
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] held_f;
    logic [1:0]  held_s;
    logic        held_e;
    int          idx;
    int          accepted;
    int          budget;
    logic        have_req;
    vec_t        v;
    logic [31:0] r;
    logic [1:0]  rs;

    tbl[0]  = mk(2'd0, 32'hFFFF_F800, 20'h00800, 1'b0);
    tbl[1]  = mk(2'd1, 32'd4094,      20'h007FF, 1'b0);
    tbl[2]  = mk(2'd3, 32'hFFFF_FFFE, 20'hFFFFF, 1'b0);
    tbl[3]  = mk(2'd2, 32'h1234_5000, 20'h12345, 1'b0);
    tbl[4]  = mk(2'd0, 32'd2048,      20'h00800, 1'b1);
    tbl[5]  = mk(2'd1, 32'd3,         20'h00001, 1'b1);
    tbl[6]  = mk(2'd2, 32'h0000_0001, 20'h00000, 1'b1);
    tbl[7]  = mk(2'd0, 32'd2047,      20'h007FF, 1'b0);
    tbl[8]  = mk(2'd1, 32'hFFFF_F000, 20'h00800, 1'b0);
    tbl[9]  = mk(2'd1, 32'd4096,      20'h00800, 1'b1);
    tbl[10] = mk(2'd3, 32'hFFF0_0000, 20'h80000, 1'b0);
    tbl[11] = mk(2'd3, 32'h000F_FFFE, 20'h7FFFF, 1'b0);
    tbl[12] = mk(2'd3, 32'h0010_0000, 20'h80000, 1'b1);
    tbl[13] = mk(2'd3, 32'h0000_0001, 20'h00000, 1'b1);

    rst = 1'b1; clr_cnt = 1'b0;
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_imm = 32'h0; bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_field", 32'(bus.out_field), 32'd0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Single request: visible two edges after the accepting edge.
    drive(tbl[0]); cycle();
    chk("first_accept", 32'(smp_acc), 32'd1);
    idle(); cycle();
    chk("latency_not_early", 32'(smp_valid), 32'd0);
    cycle();
    chk("latency_arrive", 32'(smp_valid), 32'd1);
    cycle();

    stream(1, 3);
    cycle();

    clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
    stream(4, 6);
    chk("err_cnt_three", 32'(err_cnt), 32'd3);
    stream(7, 13);
    chk("err_cnt_saturate", 32'(err_cnt), 32'd3);

    // Clear coinciding with an errored delivery.
    bus.out_ready = 1'b0;
    drive(tbl[4]); cycle(); idle(); cycle(); cycle();
    chk("clr_pre_valid", 32'(smp_valid), 32'd1);
    bus.out_ready = 1'b1; clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    chk("clr_fire", 32'(smp_fire), 32'd1);
    chk("clr_priority", 32'(err_cnt), 32'd0);

    // Backpressure: 5 stalled cycles, 3 offered requests.
    bus.out_ready = 1'b0;
    idx = 0; held_f = '0; held_s = '0; held_e = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(tbl[1 + idx]);
      cycle();
      if (smp_acc) idx++;
      if (c == 2) begin held_f = smp_field; held_s = smp_sel; held_e = smp_err; end
      if (c > 2) begin
        chk("bp_hold_valid", 32'(smp_valid), 32'd1);
        chk("bp_hold_field", 32'(smp_field), 32'(held_f));
        chk("bp_hold_sel", 32'(smp_sel), 32'(held_s));
        chk("bp_hold_err", 32'(smp_err), 32'(held_e));
      end
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready_low", 32'(smp_ready), 32'd0);
    n_deliv = 0;
    bus.out_ready = 1'b1;
    while (idx < 3) begin
      drive(tbl[1 + idx]);
      cycle();
      if (smp_acc) idx++;
    end
    idle();
    for (int c = 0; c < 4; c++) cycle();
    chk("bp_delivered", 32'(n_deliv), 32'd3);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // Reset with two results in flight.
    drive(tbl[5]); cycle(); idle(); cycle(); cycle();
    bus.out_ready = 1'b0;
    drive(tbl[1]); cycle(); drive(tbl[2]); cycle(); idle(); cycle();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_cnt", 32'(err_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_clear_cnt", 32'(err_cnt), 32'd0);
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("no_stale_output", 32'(smp_valid), 32'd0);
    end

    // Random round-trip with random stalls on both sides.
    accepted = 0; budget = 0; have_req = 1'b0;
    while (accepted < 10000 && budget < 40000) begin
      if (!have_req && $urandom_range(0, 9) < 8) begin
        rs = 2'($urandom_range(0, 3));
        r  = $urandom;
        case ($urandom_range(0, 3))
          0: r = {{20{r[11]}}, r[11:0]};
          1: r = {{11{r[20]}}, r[20:0]};
          2: r = r & 32'hFFFF_F000;
          default: ;
        endcase
        v = model(rs, r);
        drive(v);
        have_req = 1'b1;
      end else if (!have_req) begin
        idle();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      budget++;
      if (smp_acc) begin accepted++; have_req = 1'b0; idle(); end
    end
    chk("rand_accepted", 32'(accepted), 32'd10000);
    idle();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    chk("rand_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
